// File: rtl/sram_arb_pkg.sv
// Shared owner type and sram-like field widths for the inst/data arbiter.
package sram_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } own_t;

  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_SIZE_W = 2;
  localparam int SRAM_WEN_W  = 4;

endpackage

// File: rtl/owner_fifo.sv
// In-order queue of 1-bit owner tags; one entry per accepted request.
module owner_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  own_t push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output own_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          tag_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = own_t'(tag_q[rd_ptr_q]);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + (PW+1)'(1);
    if (pop_ok && !push_ok) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) tag_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between inst and data masters and routes responses by owner tag.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-inst.
module sram_like_arbiter
  import sram_arb_pkg::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inst_sram_en,
  input  logic                   inst_sram_wr,
  input  logic [SRAM_SIZE_W-1:0] inst_sram_size,
  input  logic [SRAM_WEN_W-1:0]  inst_sram_wen,
  input  logic [SRAM_ADDR_W-1:0] inst_sram_addr,
  input  logic [SRAM_DATA_W-1:0] inst_sram_wdata,
  output logic                   inst_sram_addr_ok,
  output logic                   inst_sram_data_ok,
  output logic [SRAM_DATA_W-1:0] inst_sram_rdata,
  input  logic                   data_sram_en,
  input  logic                   data_sram_wr,
  input  logic [SRAM_SIZE_W-1:0] data_sram_size,
  input  logic [SRAM_WEN_W-1:0]  data_sram_wen,
  input  logic [SRAM_ADDR_W-1:0] data_sram_addr,
  input  logic [SRAM_DATA_W-1:0] data_sram_wdata,
  output logic                   data_sram_addr_ok,
  output logic                   data_sram_data_ok,
  output logic [SRAM_DATA_W-1:0] data_sram_rdata,
  output logic                   mem_en,
  output logic                   mem_wr,
  output logic [SRAM_SIZE_W-1:0] mem_size,
  output logic [SRAM_WEN_W-1:0]  mem_wen,
  output logic [SRAM_ADDR_W-1:0] mem_addr,
  output logic [SRAM_DATA_W-1:0] mem_wdata,
  input  logic                   mem_addr_ok,
  input  logic                   mem_data_ok,
  input  logic [SRAM_DATA_W-1:0] mem_rdata,
  output logic                   arb_err
);

  own_t grant;
  logic win_vld;
  logic lock_q, lock_d;
  own_t lock_own_q, lock_own_d;
  logic err_q, err_d;
  logic fifo_full, fifo_empty;
  own_t fifo_head;
  logic push, pop;

`ifdef ARB_ROUND_ROBIN_EN
  own_t last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     last_q <= OWN_DATA;
    else if (push) last_q <= grant;
  end
`endif

  // A held lock wins only while its master still requests; withdrawal falls through to arbitration.
  always_comb begin
    win_vld = 1'b0;
    grant   = OWN_DATA;
    if (lock_q && lock_own_q == OWN_INST && inst_sram_en) begin
      win_vld = 1'b1;
      grant   = OWN_INST;
    end else if (lock_q && lock_own_q == OWN_DATA && data_sram_en) begin
      win_vld = 1'b1;
      grant   = OWN_DATA;
    end else if (inst_sram_en && data_sram_en) begin
      win_vld = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      grant   = (last_q == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
      grant   = OWN_DATA;
`endif
    end else if (data_sram_en) begin
      win_vld = 1'b1;
      grant   = OWN_DATA;
    end else if (inst_sram_en) begin
      win_vld = 1'b1;
      grant   = OWN_INST;
    end
  end

  assign mem_en    = win_vld && !fifo_full;
  assign mem_wr    = (grant == OWN_DATA) ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = (grant == OWN_DATA) ? data_sram_size  : inst_sram_size;
  assign mem_wen   = (grant == OWN_DATA) ? data_sram_wen   : inst_sram_wen;
  assign mem_addr  = (grant == OWN_DATA) ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = (grant == OWN_DATA) ? data_sram_wdata : inst_sram_wdata;

  assign inst_sram_addr_ok = mem_addr_ok && mem_en && (grant == OWN_INST);
  assign data_sram_addr_ok = mem_addr_ok && mem_en && (grant == OWN_DATA);

  assign push = mem_en && mem_addr_ok;
  assign pop  = mem_data_ok && !fifo_empty;

  assign inst_sram_data_ok = pop && (fifo_head == OWN_INST);
  assign data_sram_data_ok = pop && (fifo_head == OWN_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;
  assign arb_err           = err_q;

  // While full the lock is frozen so a stalled owner keeps its claim.
  always_comb begin
    lock_d     = lock_q;
    lock_own_d = lock_own_q;
    if (!fifo_full) begin
      if (mem_en && !mem_addr_ok) begin
        lock_d     = 1'b1;
        lock_own_d = grant;
      end else begin
        lock_d = 1'b0;
      end
    end
    err_d = err_q || (mem_data_ok && fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_INST;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      err_q      <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH(OUTST_DEPTH)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .push_tag(grant),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_en, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.OUTST_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_sram_en = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_wen = 4'h0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wr = 1; data_sram_size = 2'd2; data_sram_wen = 4'hF;
    data_sram_addr = 0; data_sram_wdata = 32'hD0D0_D0D0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ret(input logic [31:0] rd);
    mem_data_ok = 1; mem_rdata = rd;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    settle();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
    chk("rst_data_addr_ok", 32'(data_sram_addr_ok), 0);
    chk("rst_data_ok", 32'({inst_sram_data_ok, data_sram_data_ok}), 0);
    chk("rst_arb_err", 32'(arb_err), 0);
    reset = 0;
    tick();

    // Inst-only: three fetches, responses two cycles after each accept
    inst_sram_en = 1; inst_sram_addr = 32'h100; mem_addr_ok = 1; settle();
    chk("t1_mem_en", 32'(mem_en), 1);
    chk("t1_mem_addr0", mem_addr, 32'h100);
    chk("t1_inst_addr_ok", 32'(inst_sram_addr_ok), 1);
    $display("step inst fetch 0x100 accepted");
    tick();
    inst_sram_addr = 32'h104; settle();
    chk("t1_mem_addr1", mem_addr, 32'h104);
    tick();
    inst_sram_addr = 32'h108; ret(32'h11); settle();
    chk("t1_ret0_ok", 32'(inst_sram_data_ok), 1);
    chk("t1_ret0_rdata", inst_sram_rdata, 32'h11);
    chk("t1_ret0_dok", 32'(data_sram_data_ok), 0);
    tick();
    inst_sram_en = 0; mem_addr_ok = 0; ret(32'h22); settle();
    chk("t1_ret1_ok", 32'(inst_sram_data_ok), 1);
    chk("t1_ret1_rdata", inst_sram_rdata, 32'h22);
    tick();
    ret(32'h33); settle();
    chk("t1_ret2_ok", 32'(inst_sram_data_ok), 1);
    chk("t1_ret2_rdata", inst_sram_rdata, 32'h33);
    chk("t1_ret2_dok", 32'(data_sram_data_ok), 0);
    $display("step inst returns 11/22/33 checked");
    tick();
    idle(); settle();
    chk("t1_no_spurious", 32'(arb_err), 0);

    // Same-cycle request from both masters, from a fresh reset (last-owner = DATA)
    reset = 1; tick(); reset = 0; tick();
    inst_sram_en = 1; inst_sram_addr = 32'h210;
    data_sram_en = 1; data_sram_addr = 32'h220; mem_addr_ok = 1; settle();
`ifdef ARB_ROUND_ROBIN_EN
    chk("t2_first_addr", mem_addr, 32'h210);
    chk("t2_first_inst_ok", 32'(inst_sram_addr_ok), 1);
    chk("t2_first_data_ok", 32'(data_sram_addr_ok), 0);
    tick();
    inst_sram_en = 0; settle();
    chk("t2_second_addr", mem_addr, 32'h220);
    chk("t2_second_data_ok", 32'(data_sram_addr_ok), 1);
    tick();
    idle(); ret(32'h55); settle();
    chk("t2_ret0_inst", 32'(inst_sram_data_ok), 1);
    tick();
    ret(32'h66); settle();
    chk("t2_ret1_data", 32'(data_sram_data_ok), 1);
`else
    chk("t2_first_addr", mem_addr, 32'h220);
    chk("t2_first_data_ok", 32'(data_sram_addr_ok), 1);
    chk("t2_first_inst_ok", 32'(inst_sram_addr_ok), 0);
    chk("t2_first_wen", 32'(mem_wen), 32'hF);
    tick();
    data_sram_en = 0; settle();
    chk("t2_second_addr", mem_addr, 32'h210);
    chk("t2_second_inst_ok", 32'(inst_sram_addr_ok), 1);
    tick();
    idle(); ret(32'h55); settle();
    chk("t2_ret0_data", 32'(data_sram_data_ok), 1);
    chk("t2_ret0_inst", 32'(inst_sram_data_ok), 0);
    tick();
    ret(32'h66); settle();
    chk("t2_ret1_inst", 32'(inst_sram_data_ok), 1);
`endif
    $display("step dual request ordering checked");
    tick();
    idle();

    // Grant lock: inst stalls three cycles, data arrives in the second
    inst_sram_en = 1; inst_sram_addr = 32'h300; settle();
    chk("t3_lock_c0_addr", mem_addr, 32'h300);
    chk("t3_lock_c0_aok", 32'(inst_sram_addr_ok), 0);
    tick();
    data_sram_en = 1; data_sram_addr = 32'h400; settle();
    chk("t3_lock_c1_addr", mem_addr, 32'h300);
    tick();
    settle();
    chk("t3_lock_c2_addr", mem_addr, 32'h300);
    tick();
    mem_addr_ok = 1; settle();
    chk("t3_lock_acc_addr", mem_addr, 32'h300);
    chk("t3_lock_acc_iok", 32'(inst_sram_addr_ok), 1);
    chk("t3_lock_acc_dok", 32'(data_sram_addr_ok), 0);
    tick();
    inst_sram_en = 0; settle();
    chk("t3_switch_addr", mem_addr, 32'h400);
    chk("t3_switch_dok", 32'(data_sram_addr_ok), 1);
    tick();
    data_sram_en = 0; inst_sram_en = 1; inst_sram_addr = 32'h500; settle();
    chk("t3_third_iok", 32'(inst_sram_addr_ok), 1);
    $display("step lock hold then switch checked");
    tick();

    // Interleaved owners I,D,I return 0xA,0xB,0xC
    idle(); ret(32'hA); settle();
    chk("t4_A_inst", 32'(inst_sram_data_ok), 1);
    chk("t4_A_data", 32'(data_sram_data_ok), 0);
    tick();
    ret(32'hB); settle();
    chk("t4_B_inst", 32'(inst_sram_data_ok), 0);
    chk("t4_B_data", 32'(data_sram_data_ok), 1);
    chk("t4_B_rdata", data_sram_rdata, 32'hB);
    tick();
    ret(32'hC); settle();
    chk("t4_C_inst", 32'(inst_sram_data_ok), 1);
    chk("t4_C_data", 32'(data_sram_data_ok), 0);
    $display("step interleaved returns checked");
    tick();
    idle();

    // Withdrawal: data stalls, then drops en; inst wins the same cycle
    data_sram_en = 1; data_sram_addr = 32'h800; settle();
    chk("t5_wd_c0_addr", mem_addr, 32'h800);
    tick();
    data_sram_en = 0; inst_sram_en = 1; inst_sram_addr = 32'h700; mem_addr_ok = 1; settle();
    chk("t5_wd_addr", mem_addr, 32'h700);
    chk("t5_wd_iok", 32'(inst_sram_addr_ok), 1);
    tick();
    idle(); ret(32'h99); settle();
    chk("t5_wd_ret", 32'(inst_sram_data_ok), 1);
    $display("step withdrawal checked");
    tick();
    idle();

    // Full queue at depth 4
    inst_sram_en = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_sram_addr = 32'h600 + 32'(i * 4); settle();
      chk("t6_fill_iok", 32'(inst_sram_addr_ok), 1);
      tick();
    end
    settle();
    chk("t6_full_mem_en", 32'(mem_en), 0);
    chk("t6_full_iok", 32'(inst_sram_addr_ok), 0);
    tick();
    ret(32'h77); settle();
    chk("t6_pop_mem_en", 32'(mem_en), 0);
    chk("t6_pop_iok", 32'(inst_sram_data_ok), 1);
    tick();
    mem_data_ok = 0; settle();
    chk("t6_reassert_en", 32'(mem_en), 1);
    chk("t6_reassert_iok", 32'(inst_sram_addr_ok), 1);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      ret(32'h80 + 32'(i)); settle();
      chk("t6_drain_iok", 32'(inst_sram_data_ok), 1);
      tick();
    end
    $display("step full queue checked");
    idle();

    // Spurious response on an empty queue
    ret(32'hEE); settle();
    chk("t7_sp_iok", 32'(inst_sram_data_ok), 0);
    chk("t7_sp_dok", 32'(data_sram_data_ok), 0);
    tick();
    idle(); settle();
    chk("t7_err_set", 32'(arb_err), 1);
    tick(); tick();
    chk("t7_err_sticky", 32'(arb_err), 1);

    // Reset mid-burst clears queue and error immediately
    inst_sram_en = 1; inst_sram_addr = 32'h900; mem_addr_ok = 1;
    tick(); tick();
    idle();
    #2 reset = 1;
    #1;
    chk("t7_rst_err", 32'(arb_err), 0);
    tick();
    reset = 0;
    ret(32'h12); settle();
    chk("t7_rst_empty_iok", 32'(inst_sram_data_ok), 0);
    chk("t7_rst_empty_dok", 32'(data_sram_data_ok), 0);
    $display("step spurious response and async reset checked");
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
